// File: rtl/ik_swift_seq_pkg.sv
// Shared types and constants for the ik_swift iteration sequencer.
// The working DH table is a packed [joint][field] array of Q20.16 words.
package ik_swift_seq_pkg;
    localparam int W       = 36;
    localparam int N_JOINT = 6;

    localparam int THETA      = 0;
    localparam int L_OFFSET   = 1;
    localparam int L_DISTANCE = 2;
    localparam int ALPHA      = 3;

    typedef logic signed [W-1:0]   fixed_t;
    typedef fixed_t [3:0]          dh_row_t;
    typedef dh_row_t [N_JOINT-1:0] dh_table_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(W-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_CHECK  = 3'd4
    } state_t;
endpackage

// File: rtl/sat_add.sv
// Combinational W-bit signed adder that clamps to the representable range
// instead of wrapping.
module sat_add
    import ik_swift_seq_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    logic signed [W:0] sum;

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            y = sum[W] ? FIXED_MIN : FIXED_MAX;
        end else begin
            y = sum[W-1:0];
        end
    end
endmodule

// File: rtl/ik_swift_sequencer.sv
// Iteration controller: launches the ik_swift core, folds its per-joint deltas
// into the working DH table and repeats until convergence, limit or timeout.
module ik_swift_sequencer
    import ik_swift_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              max_iter,
    input  logic [W-1:0]             tol,
    input  logic [N_JOINT-1:0]       joint_type,
    input  logic [N_JOINT*4*W-1:0]   dh_init,
    output logic                     core_en,
    output logic [N_JOINT*4*W-1:0]   core_dh,
    input  logic                     core_done,
    input  logic [N_JOINT*W-1:0]     core_delta,
    output logic [N_JOINT*4*W-1:0]   dh_out,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     timeout_err,
    output logic [15:0]              iter_count
);
    localparam int JW   = (N_JOINT > 1) ? $clog2(N_JOINT) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [JW-1:0]   LAST_JOINT = JW'(N_JOINT - 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    dh_table_t              table_q, table_d;
    fixed_t [N_JOINT-1:0]   delta_q, delta_d;
    logic [JW-1:0]          joint_q, joint_d;
    logic [W-1:0]           max_q, max_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic [15:0]            iter_q, iter_d;
    logic                   done_q, done_d;
    logic                   conv_q, conv_d;
    logic                   tout_q, tout_d;
    logic                   core_en_q, core_en_d;

    logic [1:0]   field_idx;
    fixed_t       cur_field;
    fixed_t       cur_delta;
    fixed_t       sum_field;
    logic [W-1:0] cur_abs;
    logic [15:0]  eff_max;
    logic [15:0]  iter_inc;

    sat_add u_sat_add (
        .a (cur_field),
        .b (cur_delta),
        .y (sum_field)
    );

    // Datapath for the joint currently being updated.
    always_comb begin
        field_idx = joint_type[joint_q] ? 2'(THETA) : 2'(L_OFFSET);
        cur_field = table_q[joint_q][field_idx];
        cur_delta = delta_q[joint_q];
        if (!cur_delta[W-1]) begin
            cur_abs = cur_delta;
        end else if (cur_delta == FIXED_MIN) begin
            cur_abs = FIXED_MAX;
        end else begin
            cur_abs = -cur_delta;
        end
        eff_max  = (max_iter == 16'd0) ? 16'd1 : max_iter;
        iter_inc = iter_q + 16'd1;
    end

    always_comb begin
        state_d   = state_q;
        table_d   = table_q;
        delta_d   = delta_q;
        joint_d   = joint_q;
        max_d     = max_q;
        wdog_d    = wdog_q;
        iter_d    = iter_q;
        done_d    = done_q;
        conv_d    = conv_q;
        tout_d    = tout_q;
        core_en_d = 1'b0;

        // abort pre-empts every active state, including the pending table write.
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        table_d = dh_init;
                        done_d  = 1'b0;
                        conv_d  = 1'b0;
                        tout_d  = 1'b0;
                        iter_d  = 16'd0;
                        state_d = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    core_en_d = 1'b1;
                    wdog_d    = '0;
                    max_d     = '0;
                    state_d   = S_WAIT;
                end
                S_WAIT: begin
                    wdog_d = wdog_q + WD_W'(1);
                    if (core_done) begin
                        delta_d = core_delta;
                        joint_d = '0;
                        state_d = S_UPDATE;
                    end else if (wdog_q == WD_LAST) begin
                        tout_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_UPDATE: begin
                    table_d[joint_q][field_idx] = sum_field;
                    if (cur_abs > max_q) begin
                        max_d = cur_abs;
                    end
                    if (joint_q == LAST_JOINT) begin
                        state_d = S_CHECK;
                    end else begin
                        joint_d = joint_q + JW'(1);
                    end
                end
                S_CHECK: begin
                    iter_d = iter_inc;
                    if (max_q < tol) begin
                        conv_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (iter_inc == eff_max) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            table_q   <= '0;
            delta_q   <= '0;
            joint_q   <= '0;
            max_q     <= '0;
            wdog_q    <= '0;
            iter_q    <= '0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
            tout_q    <= 1'b0;
            core_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            table_q   <= table_d;
            delta_q   <= delta_d;
            joint_q   <= joint_d;
            max_q     <= max_d;
            wdog_q    <= wdog_d;
            iter_q    <= iter_d;
            done_q    <= done_d;
            conv_q    <= conv_d;
            tout_q    <= tout_d;
            core_en_q <= core_en_d;
        end
    end

    assign core_en     = core_en_q;
    assign core_dh     = table_q;
    assign dh_out      = table_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign converged   = conv_q;
    assign timeout_err = tout_q;
    assign iter_count  = iter_q;
endmodule

// File: tb/tb_ik_swift_sequencer.sv
// Scoreboard bench for ik_swift_sequencer: each solve pushes its expected
// result, and a monitor checks it when done rises.
module tb_ik_swift_sequencer;
    import ik_swift_seq_pkg::*;

    localparam int TIMEOUT_CYCLES = 4096;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [15:0]          max_iter = 16'd1;
    logic [W-1:0]         tol = '0;
    logic [N_JOINT-1:0]   joint_type = '0;
    dh_table_t            dh_init = '0;
    logic                 core_en;
    dh_table_t            core_dh;
    logic                 core_done = 1'b0;
    fixed_t [N_JOINT-1:0] core_delta = '0;
    dh_table_t            dh_out;
    logic                 busy, done, converged, timeout_err;
    logic [15:0]          iter_count;

    typedef struct {
        string       name;
        logic        conv;
        logic        tout;
        logic [15:0] iter;
        dh_table_t   tbl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_count = 0;
    logic resp_on = 1'b1;
    fixed_t [N_JOINT-1:0] resp_delta = '0;

    ik_swift_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .max_iter    (max_iter),
        .tol         (tol),
        .joint_type  (joint_type),
        .dh_init     (dh_init),
        .core_en     (core_en),
        .core_dh     (core_dh),
        .core_done   (core_done),
        .core_delta  (core_delta),
        .dh_out      (dh_out),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .timeout_err (timeout_err),
        .iter_count  (iter_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic dh_table_t base_table();
        dh_table_t t;
        for (int j = 0; j < N_JOINT; j++) begin
            for (int f = 0; f < 4; f++) begin
                t[j][f] = fixed_t'((j + 1) * 65536 + f * 4096);
            end
        end
        return t;
    endfunction

    // Queues the expected result, then issues a one-cycle start pulse.
    task automatic applyStimulus(input string name, input dh_table_t init,
                                 input logic [N_JOINT-1:0] jt, input logic [15:0] mi,
                                 input logic [W-1:0] tl, input fixed_t [N_JOINT-1:0] dl,
                                 input logic ec, input logic et, input logic [15:0] ei,
                                 input dh_table_t etbl);
        exp_t e;
        e.name = name;
        e.conv = ec;
        e.tout = et;
        e.iter = ei;
        e.tbl  = etbl;
        exp_q.push_back(e);
        @(posedge clk); #1;
        dh_init    = init;
        joint_type = jt;
        max_iter   = mi;
        tol        = tl;
        resp_delta = dl;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic waitDone(input string name, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait_done actual=0 expected=1", name);
        end
    endtask

    // Core stand-in: answers each core_en one cycle later with resp_delta.
    initial begin : core_model
        forever begin
            @(negedge clk);
            if (core_en) begin
                en_count++;
                if (resp_on) begin
                    @(posedge clk); #1;
                    core_delta = resp_delta;
                    core_done  = 1'b1;
                    @(posedge clk); #1;
                    core_done  = 1'b0;
                    core_delta = '0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.name, "_busy"}, W'(busy), W'(0));
                    checkOutput({e.name, "_converged"}, W'(converged), W'(e.conv));
                    checkOutput({e.name, "_timeout_err"}, W'(timeout_err), W'(e.tout));
                    checkOutput({e.name, "_iter_count"}, W'(iter_count), W'(e.iter));
                    checkOutput({e.name, "_core_dh_diff"}, W'(|(core_dh ^ e.tbl)), W'(0));
                    for (int j = 0; j < N_JOINT; j++) begin
                        for (int f = 0; f < 4; f++) begin
                            checkOutput($sformatf("%s_dh_%0d_%0d", e.name, j, f),
                                        dh_out[j][f], e.tbl[j][f]);
                        end
                    end
                end
            end
            prev_done = done;
        end
    end

    initial begin : stimulus
        dh_table_t            base, init, expt;
        fixed_t [N_JOINT-1:0] dl;
        logic [N_JOINT-1:0]   jt;
        int                   en0;
        int                   n;

        base = base_table();

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_core_en", W'(core_en), W'(0));
        checkOutput("rst_iter_count", W'(iter_count), W'(0));
        checkOutput("rst_dh_nonzero", W'(|dh_out), W'(0));
        #1 reset_n = 1'b1;

        // Single-iteration convergence.
        dl = '0;
        dl[0] = 36'sd50;
        expt = base;
        expt[0][THETA] = 36'sd65586;
        en0 = en_count;
        applyStimulus("conv1", base, 6'b000001, 16'd5, W'(100), dl, 1'b1, 1'b0, 16'd1, expt);
        waitDone("conv1", 200);
        checkOutput("conv1_core_en_pulses", W'(en_count - en0), W'(3'd1));

        // Iteration limit with a start pulse while busy that must be ignored.
        jt = 6'b101010;
        for (int j = 0; j < N_JOINT; j++) dl[j] = 36'sd10;
        expt = base;
        for (int j = 0; j < N_JOINT; j++) begin
            expt[j][jt[j] ? THETA : L_OFFSET] = base[j][jt[j] ? THETA : L_OFFSET] + 36'sd30;
        end
        en0 = en_count;
        applyStimulus("limit3", base, jt, 16'd3, W'(0), dl, 1'b0, 1'b0, 16'd3, expt);
        repeat (14) @(posedge clk);
        #1;
        dh_init = '0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        waitDone("limit3", 300);
        checkOutput("limit3_core_en_pulses", W'(en_count - en0), W'(3'd3));

        // max_iter of 0 behaves as a single iteration.
        expt = base;
        for (int j = 0; j < N_JOINT; j++) expt[j][L_OFFSET] = base[j][L_OFFSET] + 36'sd10;
        applyStimulus("maxiter0", base, 6'b000000, 16'd0, W'(0), dl, 1'b0, 1'b0, 16'd1, expt);
        waitDone("maxiter0", 200);

        // Saturation both ways, plus |most negative| clamping below tol = 2^35.
        init = base;
        init[0][L_OFFSET] = 36'h7_FFFF_FFFB;
        init[1][L_OFFSET] = 36'h8_0000_0003;
        init[5][L_OFFSET] = 36'sd0;
        dl = '0;
        dl[0] = 36'sd100;
        dl[1] = -36'sd10;
        dl[5] = FIXED_MIN;
        expt = init;
        expt[0][L_OFFSET] = 36'h7_FFFF_FFFF;
        expt[1][L_OFFSET] = 36'h8_0000_0000;
        expt[5][L_OFFSET] = 36'h8_0000_0000;
        applyStimulus("sat", init, 6'b000000, 16'd4, 36'h8_0000_0000, dl, 1'b1, 1'b0, 16'd1, expt);
        waitDone("sat", 200);

        // Watchdog expiry with a silent core.
        resp_on = 1'b0;
        dl = '0;
        en0 = en_count;
        applyStimulus("timeout", base, 6'b000001, 16'd2, W'(100), dl, 1'b0, 1'b1, 16'd0, base);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_en && n < 10);
        checkOutput("start_to_core_en", W'(n), W'(2));
        n = 0;
        while (!done && n < TIMEOUT_CYCLES + 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_latency", W'(n), W'(TIMEOUT_CYCLES));
        checkOutput("timeout_core_en_pulses", W'(en_count - en0), W'(3'd1));
        resp_on = 1'b1;

        // Abort while UPDATE is on joint 2.
        for (int j = 0; j < N_JOINT; j++) dl[j] = 36'sd7;
        expt = base;
        expt[0][THETA] = 36'sd65543;
        expt[1][THETA] = 36'sd131079;
        applyStimulus("abort", base, 6'b111111, 16'd4, W'(0), dl, 1'b0, 1'b0, 16'd0, expt);
        n = 0;
        while (!core_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_core_done_seen", W'(core_done), W'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        waitDone("abort", 50);

        // start and abort together while idle: nothing happens.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_start_abort_busy", W'(busy), W'(0));
        checkOutput("idle_start_abort_done", W'(done), W'(1));

        // Asynchronous reset in WAIT, then a normal solve.
        resp_on = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("wait_busy", W'(busy), W'(1));
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", W'(busy), W'(0));
        checkOutput("async_rst_done", W'(done), W'(0));
        checkOutput("async_rst_converged", W'(converged), W'(0));
        checkOutput("async_rst_timeout_err", W'(timeout_err), W'(0));
        checkOutput("async_rst_core_en", W'(core_en), W'(0));
        checkOutput("async_rst_iter_count", W'(iter_count), W'(0));
        checkOutput("async_rst_dh_nonzero", W'(|dh_out), W'(0));
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        resp_on = 1'b1;

        dl = '0;
        dl[0] = 36'sd50;
        expt = base;
        expt[0][THETA] = 36'sd65586;
        applyStimulus("post_reset", base, 6'b000001, 16'd5, W'(100), dl, 1'b1, 1'b0, 16'd1, expt);
        waitDone("post_reset", 200);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_left", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ik_swift_sequencer.md
Name: ik_swift_sequencer

Overview:
Iteration controller between the memory-mapped register block and the ik_swift core. On start it loads the initial DH table and launches one core solve. It then applies the per-joint deltas the core returns, tests for convergence and relaunches until the solution converges, the iteration limit is hit, or the core times out. The register block reads status and the working DH table through this block instead of reading the core directly.

Parameters:
N_JOINT, 6, number of joints (one DH row each)
W, 36, fixed-point word width, Q20.16 two's complement (65536 = 1.0)
TIMEOUT_CYCLES, 4096, maximum cycles to wait for core_done per launch

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; ignored while busy=1
abort  in  1  single-cycle pulse; return to idle
max_iter  in  16  iteration limit; 0 is treated as 1
tol  in  W  convergence threshold, unsigned magnitude
joint_type  in  N_JOINT  bit i = 1: joint i is rotational (update THETA); 0: translational (update L_OFFSET)
dh_init  in  N_JOINT*4*W  initial DH table [joint][THETA, L_OFFSET, L_DISTANCE, ALPHA]
core_en  out  1  launch pulse to the core
core_dh  out  N_JOINT*4*W  working DH table presented to the core
core_done  in  1  single-cycle pulse from the core; core_delta valid in the same cycle
core_delta  in  N_JOINT*W  signed per-joint delta
dh_out  out  N_JOINT*4*W  working DH table (same net as core_dh)
busy  out  1  solve in progress
done  out  1  sticky; cleared by the next accepted start
converged  out  1  sticky; valid when done=1
timeout_err  out  1  sticky; valid when done=1
iter_count  out  16  completed iterations

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE. All outputs are 0, including core_en, the working table, busy, done, converged, timeout_err and iter_count.
- IDLE
  - start=1: copy dh_init into the working table; clear done, converged, timeout_err and iter_count; go to LAUNCH.
- LAUNCH
  - Drive core_en=1 for exactly one cycle; clear the watchdog; go to WAIT.
- WAIT
  - Watchdog increments every cycle.
  - core_done=1: latch core_delta into the delta register; go to UPDATE.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no core_done: set timeout_err and done; go to IDLE.
  - If core_done arrives in that same cycle, core_done wins.
- UPDATE
  - Takes N_JOINT cycles, one joint per cycle, joint index j = 0..N_JOINT-1.
  - Target field: THETA if joint_type[j]=1, otherwise L_OFFSET.
  - Operation: field <= sat(field + delta[j]), a W+1-bit sum saturated to the W-bit signed range [-2^(W-1), 2^(W-1)-1]. No wrap.
  - Running max of |delta[j]|. |most negative| saturates to 2^(W-1)-1.
  - After joint N_JOINT-1: go to CHECK.
- CHECK
  - Single cycle; iter_count increments first.
  - Running max < tol: set converged and done; go to IDLE.
  - Else if iter_count == effective max_iter: set done (converged=0); go to IDLE.
  - Else go to LAUNCH.
- busy=1 in every state except IDLE.
- abort
  - Takes effect in any non-IDLE state on the next edge: go to IDLE; set done; leave converged and timeout_err at 0.
  - The working table keeps the values from the last completed UPDATE cycle.
  - abort has priority over start; start and abort together while IDLE: ignored.
- A core_done arriving outside WAIT is ignored.
- Latency: start to first core_en is 2 cycles. Each iteration costs core latency + N_JOINT + 3 cycles.
- Inputs max_iter, tol and joint_type are sampled live. Software must hold them stable while busy=1.

Decomposition:
- Package ik_swift_seq_pkg: W, N_JOINT, the THETA/L_OFFSET/L_DISTANCE/ALPHA index constants, the fixed_t typedef (logic signed [W-1:0]), the dh_row_t/dh_table_t packed typedefs, and the state enum.
- Sub-module sat_add: combinational W-bit saturating signed adder with W+1-bit internal sum.

Test Plan:
- Converge in 1 iteration: tol=100; joint 0 rotational, THETA=65536; core returns delta[0]=50, all others 0 -> THETA=65586, converged=1, iter_count=1, done=1.
- Iteration limit: max_iter=3, tol=0; core always returns delta=10 on every joint -> three core_en pulses, iter_count=3, converged=0, every updated field = init+30.
- Saturation: L_OFFSET = 2^35-5, joint translational, delta=+100 -> L_OFFSET=2^35-1. Negative case: field -2^35+3, delta -10 -> -2^35.
- Timeout: core never asserts core_done -> timeout_err=1 and done=1 exactly TIMEOUT_CYCLES cycles after core_en; busy=0.
- Abort mid-UPDATE at joint 2 -> joints 0-1 updated, joints 2-5 unchanged, done=1, converged=0. A start pulse during busy is ignored (iter_count unaffected).
- Asynchronous reset asserted during WAIT -> all outputs 0 immediately, without a clock edge. A fresh start after release runs normally.
